mole_scheduler: RTL and testbench

- Sequences mole appearances for the whack-a-mole game, between the LFSR segment source and the game control FSM / 7-segment driver.
- Decides when a mole appears, which segment it uses, and how long it stays lit.
- Counts hits and timed-out misses, and raises difficulty by shortening mole lifetime as hits accumulate.

---
 rtl/mole_scheduler_if.sv | 25 ++
 rtl/mole_scheduler.sv | 141 ++++++++++++++
 tb/tb_mole_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_scheduler_if.sv
// Control/status bundle between the game controller and the mole scheduler.
// master drives the game inputs; slave is the scheduler that produces mole status.
interface mole_scheduler_if;
    logic       start;
    logic       game_end;
    logic       hit;
    logic [2:0] rand_seg;
    logic       mole_valid;
    logic [2:0] mole_seg;
    logic       mole_new;
    logic [2:0] level;
    logic [7:0] hits;
    logic [7:0] misses;
    logic       sched_over;

    modport master (
        output start, game_end, hit, rand_seg,
        input  mole_valid, mole_seg, mole_new, level, hits, misses, sched_over
    );

    modport slave (
        input  start, game_end, hit, rand_seg,
        output mole_valid, mole_seg, mole_new, level, hits, misses, sched_over
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: gap/show sequencing, segment choice, hit/miss counting, levels.
// Optional macro SCHED_MISS_LIMIT_EN ends the game once misses reach MISS_LIMIT.
module mole_scheduler #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned GAP_CYCLES = 200000,
    parameter int unsigned BASE_LIFE  = 8000000,
    parameter int unsigned LIFE_DEC   = 1000000,
    parameter int unsigned MIN_LIFE   = 1000000,
    parameter int unsigned LEVEL_STEP = 4,
    parameter int unsigned MISS_LIMIT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mole_scheduler_if.slave  bus
);
    localparam int unsigned LIFE_W = CNT_W + 3;
    localparam logic [LIFE_W-1:0] BASE_L   = LIFE_W'(BASE_LIFE);
    localparam logic [LIFE_W-1:0] MIN_L    = LIFE_W'(MIN_LIFE);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        MISS_L   = 8'(MISS_LIMIT);
`ifdef SCHED_MISS_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       seg_q, seg_d;
    logic [2:0]       level_q, level_d;
    logic [7:0]       hits_q, hits_d;
    logic [7:0]       misses_q, misses_d;
    logic             valid_q, valid_d;
    logic             new_q, new_d;
    logic             over_q, over_d;

    logic [LIFE_W-1:0] life_dec, life_raw, life;
    logic [2:0]        seg_norm, seg_pick;
    logic [8:0]        hits_inc;
    logic [7:0]        misses_inc;
    logic              level_up;

    // Lifetime for the current level, segment pick, saturating counter increments
    always_comb begin
        life_dec   = LIFE_W'(LIFE_DEC) * LIFE_W'(level_q);
        life_raw   = (BASE_L > life_dec) ? (BASE_L - life_dec) : '0;
        life       = (life_raw > MIN_L) ? life_raw : MIN_L;
        seg_norm   = (bus.rand_seg == 3'd7) ? 3'd0 : bus.rand_seg;
        seg_pick   = (seg_norm != seg_q) ? seg_norm :
                     (seg_norm == 3'd6)  ? 3'd0 : (seg_norm + 3'd1);
        hits_inc   = 9'(hits_q) + 9'd1;
        level_up   = ((32'(hits_inc) % LEVEL_STEP) == 32'd0);
        misses_inc = (misses_q == 8'hFF) ? misses_q : (misses_q + 8'd1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        level_d  = level_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_GAP;
                    cnt_d    = GAP_LOAD;
                    hits_d   = '0;
                    misses_d = '0;
                    level_d  = '0;
                end
            end
            S_GAP: begin
                if (bus.game_end) begin
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    state_d = S_SHOW;
                    seg_d   = seg_pick;
                    cnt_d   = CNT_W'(life - LIFE_W'(1));
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SHOW: begin
                // game_end beats hit, hit beats timeout
                if (bus.game_end) begin
                    state_d = S_DONE;
                end else if (bus.hit) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                    hits_d  = hits_inc[8] ? 8'hFF : hits_inc[7:0];
                    if (level_up && (level_q != 3'd7)) level_d = level_q + 3'd1;
                end else if (cnt_q == '0) begin
                    misses_d = misses_inc;
                    cnt_d    = GAP_LOAD;
                    state_d  = (LIMIT_EN && (misses_inc == MISS_L)) ? S_DONE : S_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_SHOW);
        new_d   = (state_q == S_GAP) && (state_d == S_SHOW);
        over_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            seg_q    <= '0;
            level_q  <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            valid_q  <= 1'b0;
            new_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seg_q    <= seg_d;
            level_q  <= level_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            valid_q  <= valid_d;
            new_q    <= new_d;
            over_q   <= over_d;
        end
    end

    assign bus.mole_valid = valid_q;
    assign bus.mole_seg   = seg_q;
    assign bus.mole_new   = new_q;
    assign bus.level      = level_q;
    assign bus.hits       = hits_q;
    assign bus.misses     = misses_q;
    assign bus.sched_over = over_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed scenarios plus random stimulus against a phase-level model.
module tb_mole_scheduler;
    localparam int GAP_CYCLES = 4;
    localparam int BASE_LIFE  = 10;
    localparam int LIFE_DEC   = 4;
    localparam int MIN_LIFE   = 3;
    localparam int LEVEL_STEP = 2;
    localparam int MISS_LIMIT = 2;
`ifdef SCHED_MISS_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam int PH_IDLE = 0, PH_GAP = 1, PH_SHOW = 2, PH_DONE = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mole_scheduler_if bus();

    mole_scheduler #(
        .CNT_W(8), .GAP_CYCLES(GAP_CYCLES), .BASE_LIFE(BASE_LIFE), .LIFE_DEC(LIFE_DEC),
        .MIN_LIFE(MIN_LIFE), .LEVEL_STEP(LEVEL_STEP), .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game model: phase plus cycles remaining in it
    int m_ph, m_left, m_seg, m_level, m_hits, m_misses;
    bit m_new;

    function automatic int life_of(input int lvl);
        int l;
        l = BASE_LIFE - lvl * LIFE_DEC;
        if (l < MIN_LIFE) l = MIN_LIFE;
        return l;
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_left = 0; m_seg = 0; m_level = 0;
        m_hits = 0; m_misses = 0; m_new = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit ge, input bit h, input int rs);
        int s;
        m_new = 1'b0;
        case (m_ph)
            PH_IDLE, PH_DONE: if (st) begin
                m_ph = PH_GAP; m_left = GAP_CYCLES; m_hits = 0; m_misses = 0; m_level = 0;
            end
            PH_GAP: if (ge) m_ph = PH_DONE;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        s = (rs == 7) ? 0 : rs;
                        if (s == m_seg) s = (s + 1) % 7;
                        m_seg = s; m_left = life_of(m_level); m_ph = PH_SHOW; m_new = 1'b1;
                    end
                end
            PH_SHOW: if (ge) m_ph = PH_DONE;
                else if (h) begin
                    if (((m_hits + 1) % LEVEL_STEP) == 0 && m_level < 7) m_level++;
                    if (m_hits < 255) m_hits++;
                    m_ph = PH_GAP; m_left = GAP_CYCLES;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_misses < 255) m_misses++;
                        m_left = GAP_CYCLES;
                        m_ph = (LIMIT_EN && m_misses == MISS_LIMIT) ? PH_DONE : PH_GAP;
                    end
                end
            default: ;
        endcase
    endtask

    // Drive inputs for one cycle, advance model, return #1 after the edge
    task automatic step(input bit st, input bit ge, input bit h, input logic [2:0] rs);
        bus.start = st; bus.game_end = ge; bus.hit = h; bus.rand_seg = rs;
        @(posedge clk);
        model_step(st, ge, h, int'(rs));
        #1;
        bus.start = 1'b0; bus.hit = 1'b0;
    endtask

    task automatic wait_valid(input logic [2:0] rs, output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step(1'b0, 1'b0, 1'b0, rs);
            n++;
            if (bus.mole_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [24:0] got;
        bus.start = 0; bus.game_end = 0; bus.hit = 0; bus.rand_seg = 0;
        rst_n = 1'b0;
        #12;
        got = {bus.mole_valid, bus.mole_seg, bus.mole_new, bus.level, bus.hits, bus.misses, bus.sched_over};
        checks++;
        if (got !== 25'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", got); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 3'd0);
        checks++;
        if (bus.sched_over !== 1'b0 || bus.mole_valid !== 1'b0) begin
            errors++; $display("FAIL game_end_in_idle over=%b valid=%b exp 0/0", bus.sched_over, bus.mole_valid);
        end
        step(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_first_mole();
        int n, lat; bit ok;
        step(1'b1, 1'b0, 1'b0, 3'd3);
        lat = 1;
        wait_valid(3'd3, n, ok);
        lat += n;
        checks++;
        if (!ok || lat != GAP_CYCLES + 1) begin errors++; $display("FAIL first_latency got=%0d ok=%b exp=%0d", lat, ok, GAP_CYCLES + 1); end
        checks++;
        if (bus.mole_seg !== 3'd3) begin errors++; $display("FAIL first_seg got=%0d exp=3", bus.mole_seg); end
        checks++;
        if (bus.mole_new !== 1'b1) begin errors++; $display("FAIL first_new got=%b exp=1", bus.mole_new); end
    endtask

    task automatic test_timeout();
        int lit, n; bit ok;
        lit = 1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd7);
            if (!bus.mole_valid) break;
            if (lit == 1) begin
                checks++;
                if (bus.mole_new !== 1'b0) begin errors++; $display("FAIL new_single_pulse got=%b exp=0", bus.mole_new); end
            end
            lit++;
        end
        checks++;
        if (lit != BASE_LIFE) begin errors++; $display("FAIL lit_level0 got=%0d exp=%0d", lit, BASE_LIFE); end
        checks++;
        if (bus.misses !== 8'd1 || bus.hits !== 8'd0) begin errors++; $display("FAIL miss_count misses=%0d hits=%0d exp 1/0", bus.misses, bus.hits); end
        wait_valid(3'd7, n, ok);
        checks++;
        if (!ok || n != GAP_CYCLES) begin errors++; $display("FAIL gap_length got=%0d ok=%b exp=%0d", n, ok, GAP_CYCLES); end
        checks++;
        if (bus.mole_seg !== 3'd0) begin errors++; $display("FAIL seg_from7 got=%0d exp=0", bus.mole_seg); end
    endtask

    task automatic test_levels();
        int n, lit; bit ok, all_lit;
        step(1'b0, 1'b0, 1'b1, 3'd0);
        checks++;
        if (bus.mole_valid !== 1'b0 || bus.hits !== 8'd1 || bus.level !== 3'd0) begin
            errors++; $display("FAIL hit1 valid=%b hits=%0d level=%0d exp 0/1/0", bus.mole_valid, bus.hits, bus.level);
        end
        wait_valid(3'd0, n, ok);
        checks++;
        if (!ok || bus.mole_seg !== 3'd1) begin errors++; $display("FAIL seg_repeat got=%0d ok=%b exp=1", bus.mole_seg, ok); end
        step(1'b0, 1'b0, 1'b1, 3'd5);
        checks++;
        if (bus.hits !== 8'd2 || bus.level !== 3'd1) begin errors++; $display("FAIL level1 hits=%0d level=%0d exp 2/1", bus.hits, bus.level); end
        wait_valid(3'd5, n, ok);
        all_lit = ok;
        for (int i = 1; i < BASE_LIFE - LIFE_DEC; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd2);
            if (!bus.mole_valid) all_lit = 1'b0;
        end
        checks++;
        if (!all_lit) begin errors++; $display("FAIL life_level1 valid=%b exp=1 through cycle %0d", bus.mole_valid, BASE_LIFE - LIFE_DEC); end
        step(1'b0, 1'b0, 1'b1, 3'd2);
        checks++;
        if (bus.hits !== 8'd3 || bus.misses !== 8'd1 || bus.mole_valid !== 1'b0 || bus.level !== 3'd1) begin
            errors++; $display("FAIL hit_vs_timeout hits=%0d misses=%0d valid=%b level=%0d exp 3/1/0/1", bus.hits, bus.misses, bus.mole_valid, bus.level);
        end
        wait_valid(3'd4, n, ok);
        step(1'b0, 1'b0, 1'b1, 3'd6);
        checks++;
        if (!ok || bus.hits !== 8'd4 || bus.level !== 3'd2) begin errors++; $display("FAIL level2 hits=%0d level=%0d exp 4/2", bus.hits, bus.level); end
        wait_valid(3'd6, n, ok);
        lit = 1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd1);
            if (!bus.mole_valid) break;
            lit++;
        end
        checks++;
        if (!ok || lit != MIN_LIFE) begin errors++; $display("FAIL life_floor got=%0d exp=%0d", lit, MIN_LIFE); end
        checks++;
        if (bus.misses !== 8'd2) begin errors++; $display("FAIL miss_count2 got=%0d exp=2", bus.misses); end
`ifdef SCHED_MISS_LIMIT_EN
        checks++;
        if (bus.sched_over !== 1'b1) begin errors++; $display("FAIL miss_limit_over got=%b exp=1", bus.sched_over); end
        step(1'b0, 1'b0, 1'b0, 3'd1);
        checks++;
        if (bus.sched_over !== 1'b1 || bus.mole_valid !== 1'b0) begin errors++; $display("FAIL miss_limit_hold over=%b valid=%b exp 1/0", bus.sched_over, bus.mole_valid); end
        step(1'b1, 1'b0, 1'b0, 3'd1);
        checks++;
        if (bus.sched_over !== 1'b0 || bus.hits !== 8'd0 || bus.misses !== 8'd0 || bus.level !== 3'd0) begin
            errors++; $display("FAIL restart over=%b hits=%0d misses=%0d level=%0d exp 0/0/0/0", bus.sched_over, bus.hits, bus.misses, bus.level);
        end
`else
        checks++;
        if (bus.sched_over !== 1'b0) begin errors++; $display("FAIL no_miss_limit over=%b exp=0", bus.sched_over); end
        step(1'b1, 1'b0, 1'b0, 3'd1);
        checks++;
        if (bus.hits !== 8'd4 || bus.level !== 3'd2 || bus.misses !== 8'd2) begin
            errors++; $display("FAIL start_in_gap hits=%0d level=%0d misses=%0d exp 4/2/2", bus.hits, bus.level, bus.misses);
        end
`endif
    endtask

    task automatic test_game_end_hit();
        int n; bit ok; logic [7:0] h0; logic [2:0] s0;
        h0 = bus.hits;
        step(1'b0, 1'b0, 1'b1, 3'd3);
        checks++;
        if (bus.hits !== h0) begin errors++; $display("FAIL hit_in_gap got=%0d exp=%0d", bus.hits, h0); end
        wait_valid(3'd3, n, ok);
        h0 = bus.hits; s0 = bus.mole_seg;
        step(1'b0, 1'b1, 1'b1, 3'd5);
        checks++;
        if (!ok || bus.mole_valid !== 1'b0 || bus.sched_over !== 1'b1 || bus.hits !== h0) begin
            errors++; $display("FAIL end_beats_hit valid=%b over=%b hits=%0d exp 0/1/%0d", bus.mole_valid, bus.sched_over, bus.hits, h0);
        end
        step(1'b0, 1'b0, 1'b0, 3'd5);
        checks++;
        if (bus.sched_over !== 1'b1 || bus.mole_seg !== s0 || bus.mole_valid !== 1'b0) begin
            errors++; $display("FAIL done_hold over=%b seg=%0d valid=%b exp 1/%0d/0", bus.sched_over, bus.mole_seg, bus.mole_valid, s0);
        end
    endtask

    task automatic test_start_with_game_end();
        step(1'b1, 1'b1, 1'b0, 3'd2);
        checks++;
        if (bus.sched_over !== 1'b0 || bus.hits !== 8'd0 || bus.misses !== 8'd0) begin
            errors++; $display("FAIL start_while_end over=%b hits=%0d misses=%0d exp 0/0/0", bus.sched_over, bus.hits, bus.misses);
        end
        step(1'b0, 1'b1, 1'b0, 3'd2);
        checks++;
        if (bus.sched_over !== 1'b1) begin errors++; $display("FAIL end_after_start got=%b exp=1", bus.sched_over); end
        step(1'b0, 1'b0, 1'b0, 3'd2);
    endtask

    task automatic test_random();
        logic [24:0] got, exp;
        bit ge, st, h;
        logic [2:0] rs;
        ge = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 0 || i == 2000) begin
                #2 rst_n = 1'b0;
                #1;
                got = {bus.mole_valid, bus.mole_seg, bus.mole_new, bus.level, bus.hits, bus.misses, bus.sched_over};
                checks++;
                if (got !== 25'd0) begin errors++; $display("FAIL async_reset cycle=%0d got=%h exp=0", i, got); end
                model_reset();
                @(posedge clk); #1;
                rst_n = 1'b1;
                ge = 1'b0;
            end
            if ($urandom_range(0, 249) == 0) ge = !ge;
            st = ($urandom_range(0, 29) == 0);
            h  = ($urandom_range(0, 5) == 0);
            rs = 3'($urandom_range(0, 7));
            step(st, ge, h, rs);
            exp = {m_ph == PH_SHOW, 3'(m_seg), m_new, 3'(m_level), 8'(m_hits), 8'(m_misses), m_ph == PH_DONE};
            got = {bus.mole_valid, bus.mole_seg, bus.mole_new, bus.level, bus.hits, bus.misses, bus.sched_over};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random cycle=%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_first_mole();
        test_timeout();
        test_levels();
        test_game_end_hit();
        test_start_with_game_end();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
